// File: rtl/arr_pkg.sv
// Shared types and index helpers for the array stream loader.
package arr_pkg;

    localparam int DEFAULT_WIDTH = 16;

    // Element word at the default width; blocks with a different WIDTH
    // declare their own element type locally.
    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // Loader state encoding: collecting words, or presenting a frame.
    typedef enum logic {
        ST_FILL = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    // Row of a linear row-major index.
    function automatic int unsigned idx_row(input int unsigned i, input int unsigned cols);
        return i / cols;
    endfunction

    // Column of a linear row-major index.
    function automatic int unsigned idx_col(input int unsigned i, input int unsigned cols);
        return i % cols;
    endfunction

endpackage

// File: rtl/array_stream_loader.sv
// Packs a valid/ready stream of words into a ROWS x COLS array, row-major,
// and hands the completed (or IN_LAST-shortened) frame over with valid/ready.
module array_stream_loader
    import arr_pkg::*;
#(
    parameter int ROWS  = 2,
    parameter int COLS  = 2,
    parameter int WIDTH = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [WIDTH-1:0]                    in_data,
    input  logic                                in_valid,
    input  logic                                in_last,
    output logic                                in_ready,
    output logic [WIDTH-1:0]                    arr [ROWS][COLS],
    output logic                                arr_valid,
    input  logic                                arr_ready,
    output logic                                short,
    output logic [$clog2(ROWS*COLS+1)-1:0]      fill_cnt
);

    localparam int N  = ROWS * COLS;
    localparam int CW = $clog2(N + 1);
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int KW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef logic [WIDTH-1:0] elem_t;

    state_t          state_q;
    state_t          state_d;
    logic            ready_q;
    logic            short_q;
    logic [CW-1:0]   cnt_q;
    elem_t           arr_q [ROWS][COLS];

    logic            accept;
    logic            last_slot;
    logic [RW-1:0]   wr_row;
    logic [KW-1:0]   wr_col;

    // A word is taken only when the registered ready flag is up, so nothing
    // on the input side reaches the outputs combinationally.
    assign accept    = in_valid && ready_q;
    assign last_slot = (cnt_q == CW'(N - 1));
    assign wr_row    = RW'(idx_row(32'(cnt_q), COLS));
    assign wr_col    = KW'(idx_col(32'(cnt_q), COLS));

    // Next-state decision: close the frame on the final slot or IN_LAST,
    // reopen it once the consumer takes the held frame.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        case (state_q)
            ST_FILL: if (accept && (last_slot || in_last)) state_d = ST_HOLD;
            ST_HOLD: if (arr_ready)                       state_d = ST_FILL;
            default: state_d = ST_FILL;
        endcase
    end

    // State, ready flag, counter, short flag and frame storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_FILL;
            ready_q <= 1'b0;
            short_q <= 1'b0;
            cnt_q   <= '0;
            // NOTE: the frame is a small register array that must read as zero
            // straight out of reset (zero-fill), so every element is reset here.
            for (int r = 0; r < ROWS; r++)
                for (int c = 0; c < COLS; c++)
                    arr_q[r][c] <= '0;
        end else begin
            // NOTE: non-blocking assignments so all registers update from
            // pre-edge values regardless of statement order.
            state_q <= state_d;
            ready_q <= (state_d == ST_FILL);
            if (state_q == ST_FILL) begin
                if (accept) begin
                    arr_q[wr_row][wr_col] <= in_data;
                    cnt_q                 <= cnt_q + CW'(1);
                    short_q               <= in_last && !last_slot;
                end
            end else if (arr_ready) begin
                cnt_q   <= '0;
                short_q <= 1'b0;
                for (int r = 0; r < ROWS; r++)
                    for (int c = 0; c < COLS; c++)
                        arr_q[r][c] <= '0;
            end
        end
    end

    assign in_ready  = ready_q;
    assign arr_valid = (state_q == ST_HOLD);
    assign short     = short_q;
    assign fill_cnt  = cnt_q;
    assign arr       = arr_q;

endmodule

// File: tb/tb_array_stream_loader.sv
// Directed and random stimulus for array_stream_loader against a frame model
// kept as a queue of accepted words.
module tb_array_stream_loader;
    import arr_pkg::*;

    localparam int ROWS  = 2;
    localparam int COLS  = 2;
    localparam int WIDTH = 16;
    localparam int N     = ROWS * COLS;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic [WIDTH-1:0] arr [ROWS][COLS];
    logic             arr_valid;
    logic             arr_ready;
    logic             short;
    logic [2:0]       fill_cnt;

    int errors = 0;
    int checks = 0;

    // Reference model: accepted words of the current frame, held/short flags.
    word_t m_words[$];
    bit    m_hold;
    bit    m_short;
    bit    m_ready;

    array_stream_loader #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .arr       (arr),
        .arr_valid (arr_valid),
        .arr_ready (arr_ready),
        .short     (short),
        .fill_cnt  (fill_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_words.delete();
        m_hold  = 1'b0;
        m_short = 1'b0;
        m_ready = 1'b0;
    endfunction

    // Apply one clock edge's worth of behaviour using the current inputs.
    function automatic void model_edge();
        if (!m_hold) begin
            if (m_ready && in_valid) begin
                m_words.push_back(in_data);
                if (m_words.size() == N || in_last) begin
                    m_hold  = 1'b1;
                    m_short = (m_words.size() != N);
                end
            end
        end else if (arr_ready) begin
            m_words.delete();
            m_hold  = 1'b0;
            m_short = 1'b0;
        end
        m_ready = !m_hold;
    endfunction

    task automatic check_all(input string step);
        chk({step, ".in_ready"},  32'(in_ready),  32'(m_ready));
        chk({step, ".arr_valid"}, 32'(arr_valid), 32'(m_hold));
        chk({step, ".short"},     32'(short),     32'(m_short));
        chk({step, ".fill_cnt"},  32'(fill_cnt),  32'(m_words.size()));
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                int    idx;
                word_t exp;
                idx = r * COLS + c;
                exp = (idx < m_words.size()) ? m_words[idx] : '0;
                chk($sformatf("%s.arr[%0d][%0d]", step, r, c), 32'(arr[r][c]), 32'(exp));
            end
        end
    endtask

    // One cycle: drive at the falling edge, model the rising edge, check at the next fall.
    task automatic step(input string tag, input logic v, input logic [WIDTH-1:0] d,
                        input logic l, input logic ar);
        in_valid  = v;
        in_data   = d;
        in_last   = l;
        arr_ready = ar;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        arr_ready = 1'b0;
        model_reset();

        // 1. Reset state, then ready one edge after release.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        step("release", 0, 16'h0000, 0, 0);
        chk("release.ready_const", 32'(in_ready), 32'd1);

        // 2. Full frame back-to-back.
        step("full0", 1, 16'h0011, 0, 0);
        step("full1", 1, 16'h0022, 0, 0);
        step("full2", 1, 16'h0033, 0, 0);
        step("full3", 1, 16'h0044, 0, 0);
        chk("full.a00", 32'(arr[0][0]), 32'h0011);
        chk("full.a01", 32'(arr[0][1]), 32'h0022);
        chk("full.a10", 32'(arr[1][0]), 32'h0033);
        chk("full.a11", 32'(arr[1][1]), 32'h0044);
        chk("full.valid", 32'(arr_valid), 32'd1);
        chk("full.short", 32'(short), 32'd0);
        chk("full.cnt", 32'(fill_cnt), 32'd4);
        step("full_rel", 0, 16'h0000, 0, 1);

        // 3. Short frame ended by IN_LAST.
        step("short0", 1, 16'hAAAA, 0, 0);
        step("short1", 1, 16'hBBBB, 1, 0);
        chk("short.a00", 32'(arr[0][0]), 32'hAAAA);
        chk("short.a01", 32'(arr[0][1]), 32'hBBBB);
        chk("short.a10", 32'(arr[1][0]), 32'h0000);
        chk("short.a11", 32'(arr[1][1]), 32'h0000);
        chk("short.flag", 32'(short), 32'd1);
        chk("short.cnt", 32'(fill_cnt), 32'd2);

        // 4. Backpressure in HOLD with a waiting word.
        for (int i = 0; i < 5; i++) step("bp_hold", 1, 16'h1234, 0, 0);
        chk("bp.ready", 32'(in_ready), 32'd0);
        chk("bp.a00", 32'(arr[0][0]), 32'hAAAA);
        step("bp_rel", 1, 16'h1234, 0, 1);
        step("bp_take", 1, 16'h1234, 0, 0);
        chk("bp.next_a00", 32'(arr[0][0]), 32'h1234);
        chk("bp.next_cnt", 32'(fill_cnt), 32'd1);
        step("bp_w1", 1, 16'h5555, 0, 0);
        step("bp_w2", 1, 16'h6666, 0, 0);
        step("bp_w3", 1, 16'h7777, 1, 0);
        chk("bp.last_on_n", 32'(short), 32'd0);
        step("bp_rel2", 0, 16'h0000, 0, 1);

        // 5. Input gaps: only handshaken words land.
        for (int i = 0; i < 8; i++)
            step("gaps", (i % 2) == 0, 16'(16'hC000 + i), 0, 0);
        chk("gaps.a10", 32'(arr[1][0]), 32'hC004);
        step("gaps_rel", 0, 16'h0000, 0, 1);

        // 6. Asynchronous reset mid-frame.
        step("mid0", 1, 16'hD001, 0, 0);
        step("mid1", 1, 16'hD002, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check_all("mid_rst");
        chk("mid_rst.cnt_const", 32'(fill_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step("mid_rel", 0, 16'h0000, 0, 0);
        step("mid_f0", 1, 16'hE001, 0, 0);
        step("mid_f1", 1, 16'hE002, 0, 0);
        step("mid_f2", 1, 16'hE003, 0, 0);
        step("mid_f3", 1, 16'hE004, 0, 0);
        chk("mid.a00", 32'(arr[0][0]), 32'hE001);
        step("mid_frel", 0, 16'h0000, 0, 1);

        // 7. Random traffic against the model.
        for (int i = 0; i < 300; i++)
            step("rand", 1'($urandom_range(0, 1)), 16'($urandom),
                 ($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
